// File: rtl/fp_decode_serial.sv
// Serial float decoder: turns (sign, exponent, significand) into a 12-bit
// two's-complement value by shifting the significand left one bit per cycle,
// then negating if the sign is set. Valid/ready on both sides.
module fp_decode_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic [2:0]  exponent,
  input  logic [3:0]  significand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] D,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StShift, StFin, StDone} state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [11:0] mag_q, mag_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] d_q, d_d;
  logic        out_valid_q, out_valid_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sign_q      <= 1'b0;
      mag_q       <= 12'h000;
      cnt_q       <= 3'd0;
      d_q         <= 12'h000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath updates; everything holds unless a state acts on it.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    d_d         = d_q;
    out_valid_d = out_valid_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d  = sign;
          mag_d   = {8'b0, significand};
          cnt_d   = exponent;
          state_d = StShift;
        end
      end
      StShift: begin
        // One bit per cycle; the zero-count cycle costs one extra edge.
        if (cnt_q == 3'd0) begin
          state_d = StFin;
        end else begin
          mag_d = {mag_q[10:0], 1'b0};
          cnt_d = cnt_q - 3'd1;
        end
      end
      StFin: begin
        d_d         = sign_q ? (~mag_q + 12'd1) : mag_q;
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign D         = d_q;

endmodule

// File: tb/tb_fp_decode_serial.sv
// Self-checking bench for fp_decode_serial: directed vectors, hold/backpressure,
// mid-flight reset and a randomized back-to-back stream against a value model.
module tb_fp_decode_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign = 1'b0;
  logic [2:0]  exponent = 3'd0;
  logic [3:0]  significand = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] D;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  fp_decode_serial dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sign        (sign),
    .exponent    (exponent),
    .significand (significand),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .D           (D),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference value: signed integer arithmetic, truncated to 12 bits.
  function automatic logic [11:0] model(input logic s, input logic [2:0] e,
                                        input logic [3:0] m);
    int v;
    v = int'(m) * (1 << e);
    if (s) v = -v;
    return v[11:0];
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs;
    sign        = 1'($urandom_range(1, 0));
    exponent    = 3'($urandom_range(7, 0));
    significand = 4'($urandom_range(15, 0));
  endtask

  task automatic test_reset;
    int lat;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (3) step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid);
    else n_pass++;
    n_total++; if (D !== 12'h000) $display("FAIL rst_D: got %h want 000", D);
    else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
    else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready);
    else n_pass++;
    // Transfer on the very first edge after reset release.
    sign = 1'b0; exponent = 3'd1; significand = 4'd3; in_valid = 1'b1;
    rst = 1'b0;
    step();
    in_valid = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL first_edge_busy: got %b want 1", busy);
    else n_pass++;
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    n_total++; if (D !== 12'h006) $display("FAIL first_edge_D: got %h want 006", D);
    else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // One conversion; hold > 0 keeps out_ready low for that many cycles while
  // new words are offered on the input, which must be ignored.
  task automatic run_one(input string name, input logic s, input logic [2:0] e,
                         input logic [3:0] m, input logic rdy, input int hold);
    int lat;
    logic [11:0] want;
    want = model(s, e, m);
    lat = 0;
    while (!in_ready && lat < 20) begin step(); lat++; end
    sign = s; exponent = e; significand = m; in_valid = 1'b1; out_ready = rdy;
    step();
    in_valid = 1'b0;
    scramble_inputs();
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    n_total++;
    if (lat !== int'(e) + 2) $display("FAIL %s_latency: got %0d want %0d", name, lat, e + 2);
    else n_pass++;
    n_total++; if (D !== want) $display("FAIL %s_D: got %h want %h", name, D, want);
    else n_pass++;
    n_total++;
    if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL %s_busy: got busy=%b in_ready=%b want 1/0", name, busy, in_ready);
    else n_pass++;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      scramble_inputs();
      step();
      n_total++;
      if (D !== want || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL %s_hold: got D=%h ov=%b ir=%b want %h/1/0", name, D, out_valid,
                 in_ready, want);
      else n_pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || D !== want)
      $display("FAIL %s_handoff: got ov=%b ir=%b D=%h want 0/1/%h", name, out_valid, in_ready,
               D, want);
    else n_pass++;
    if (hold > 0) begin
      repeat (3) step();
      n_total++; if (busy !== 1'b0) $display("FAIL %s_no_capture: got busy=%b want 0", name, busy);
      else n_pass++;
    end
  endtask

  task automatic test_vectors;
    run_one("v88", 1'b0, 3'd3, 4'b1011, 1'b0, 0);
    run_one("vneg1920", 1'b1, 3'd7, 4'b1111, 1'b1, 0);
    run_one("vzero", 1'b1, 3'd0, 4'b0000, 1'b1, 0);
    run_one("vpos1920", 1'b0, 3'd7, 4'b1111, 1'b0, 0);
    run_one("vunnorm", 1'b1, 3'd5, 4'b0001, 1'b1, 0);
    for (int i = 0; i < 8; i++)
      run_one("vrand", 1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)),
              4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 0);
  endtask

  task automatic test_hold;
    run_one("hold", 1'b1, 3'd2, 4'b0101, 1'b0, 10);
  endtask

  task automatic test_reset_midflight;
    int lat;
    logic seen;
    lat = 0;
    while (!in_ready && lat < 20) begin step(); lat++; end
    sign = 1'b0; exponent = 3'd6; significand = 4'd9; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || D !== 12'h000 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL midrst_state: got ov=%b D=%h ir=%b busy=%b want 0/000/1/0", out_valid, D,
               in_ready, busy);
    else n_pass++;
    seen = 1'b0;
    out_ready = 1'b1;
    repeat (15) begin step(); if (out_valid) seen = 1'b1; end
    out_ready = 1'b0;
    n_total++; if (seen !== 1'b0) $display("FAIL midrst_no_result: got %b want 0", seen);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [11:0] exp_q[$];
    logic [11:0] want;
    logic acc;
    int acc_cnt, res_cnt, cyc, last_acc, last_e;
    acc_cnt = 0; res_cnt = 0; cyc = 0; last_acc = -1; last_e = 0;
    out_ready = 1'b1;
    scramble_inputs();
    in_valid = 1'b1;
    while ((acc_cnt < 200 || exp_q.size() != 0) && cyc < 4000) begin
      acc = in_ready && in_valid;
      step();
      cyc++;
      if (acc) begin
        exp_q.push_back(model(sign, exponent, significand));
        if (last_acc >= 0) begin
          n_total++;
          if (cyc - last_acc !== last_e + 4)
            $display("FAIL b2b_interval: got %0d want %0d", cyc - last_acc, last_e + 4);
          else n_pass++;
        end
        last_acc = cyc;
        last_e = int'(exponent);
        acc_cnt++;
        if (acc_cnt < 200) scramble_inputs();
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL b2b_extra: got result %h want none", D);
        end else begin
          want = exp_q.pop_front();
          if (D !== want) $display("FAIL b2b_D: got %h want %h", D, want);
          else n_pass++;
        end
        res_cnt++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_total++; if (acc_cnt !== 200) $display("FAIL b2b_accepts: got %0d want 200", acc_cnt);
    else n_pass++;
    n_total++; if (res_cnt !== 200) $display("FAIL b2b_results: got %0d want 200", res_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_reset_midflight();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
